column_frame_buffer: RTL

- Double-buffered per-column store for raycast results (distance + texture/UV), placed between the column producer (CPU/raycaster) and the GPU scanout.
- The GPU reads the front bank by column index while the producer writes the back bank.
- Banks swap only at frame boundaries, on request, so scanout never tears.
- A built-in fill engine clears or initialises the back bank. This replaces static preloaded column tables.

---
 rtl/column_frame_buffer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/column_frame_buffer.sv
// Double-buffered per-column store of {distance, texture} between the raycaster and scanout.
// The GPU reads the front bank, the producer or the fill engine writes the back bank, and banks swap at frame_start.
module column_frame_buffer #(
  parameter int COLUMNS    = 320,
  parameter int IDX_WIDTH  = 9,
  parameter int DIST_WIDTH = 16,
  parameter int TEX_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [IDX_WIDTH-1:0]  wr_index,
  input  logic [DIST_WIDTH-1:0] wr_distance,
  input  logic [TEX_WIDTH-1:0]  wr_texture,
  input  logic [IDX_WIDTH-1:0]  rd_index,
  output logic [DIST_WIDTH-1:0] rd_distance,
  output logic [TEX_WIDTH-1:0]  rd_texture,
  input  logic                  swap_req,
  input  logic                  frame_start,
  input  logic                  fill_start,
  input  logic [DIST_WIDTH-1:0] fill_distance,
  input  logic [TEX_WIDTH-1:0]  fill_texture,
  output logic                  active_buffer,
  output logic                  swap_pending,
  output logic                  fill_busy,
  output logic                  wr_error
);

  localparam int ENTRY_W = DIST_WIDTH + TEX_WIDTH;
  localparam logic [IDX_WIDTH-1:0] LAST_COL = IDX_WIDTH'(COLUMNS - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t                state_q, state_d;
  logic [IDX_WIDTH-1:0]  fill_count_q, fill_count_d;
  logic                  active_q, active_d;
  logic                  pending_q, pending_d;
  logic                  error_q, error_d;

  logic                  mem_we;
  logic [IDX_WIDTH-1:0]  mem_addr;
  logic [ENTRY_W-1:0]    mem_data;
  logic [ENTRY_W-1:0]    mem [2][COLUMNS];

  logic                  wr_in_range;
  logic                  rd_in_range;

  assign wr_in_range = (wr_index <= LAST_COL);
  assign rd_in_range = (rd_index <= LAST_COL);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= IDLE;
      fill_count_q <= '0;
      active_q     <= 1'b0;
      pending_q    <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_count_q <= fill_count_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      error_q      <= error_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fill_count_d = fill_count_q;
    active_d     = active_q;
    pending_d    = pending_q;
    error_d      = error_q;
    mem_we       = 1'b0;
    mem_addr     = wr_index;
    mem_data     = {wr_distance, wr_texture};

    case (state_q)
      IDLE: begin
        if (wr_en && wr_in_range) begin
          mem_we = 1'b1;
        end
        if (fill_start) begin
          state_d = FILL;
        end
      end
      FILL: begin
        // The fill engine owns the single write port; producer writes are dropped.
        mem_we   = 1'b1;
        mem_addr = fill_count_q;
        mem_data = {fill_distance, fill_texture};
        if (fill_count_q == LAST_COL) begin
          state_d      = IDLE;
          fill_count_d = '0;
        end else begin
          fill_count_d = fill_count_q + IDX_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (wr_en && (!wr_in_range || state_q == FILL)) begin
      error_d = 1'b1;
    end

    // Swapping is held off while filling so the bank being filled never becomes front half-done.
    if (frame_start && (pending_q || swap_req) && state_q == IDLE) begin
      active_d  = ~active_q;
      pending_d = 1'b0;
    end else if (swap_req) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[~active_q][mem_addr] <= mem_data;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rd_distance <= '0;
      rd_texture  <= '0;
    end else if (rd_in_range) begin
      {rd_distance, rd_texture} <= mem[active_q][rd_index];
    end else begin
      rd_distance <= '0;
      rd_texture  <= '0;
    end
  end

  assign active_buffer = active_q;
  assign swap_pending  = pending_q;
  assign fill_busy     = (state_q == FILL);
  assign wr_error      = error_q;

endmodule
